// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register-write scoreboard: register file geometry,
// per-register counter width and the total in-flight counter width.
package reg_scoreboard_pkg;
  localparam int NREG   = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;
  localparam int OUT_W  = 3;

  localparam logic [ADDR_W-1:0] REG_ZERO  = 5'd0;
  localparam logic [CNT_W-1:0]  CNT_ZERO  = 2'd0;
  localparam logic [CNT_W-1:0]  CNT_ONE   = 2'd1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = 2'd3;
  localparam logic [OUT_W-1:0]  INFL_ZERO = 3'd0;
  localparam logic [OUT_W-1:0]  INFL_ONE  = 3'd1;
  localparam logic [OUT_W-1:0]  INFL_MAX  = 3'd7;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue / load-return / commit / ID-query signal bundle of the scoreboard.
// master drives pipeline events and queries, slave is the scoreboard.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic              issue_valid;
  logic              issue_rd_w_en;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_is_load;
  logic              issue_ready;
  logic              lsu_r_valid;
  logic [ADDR_W-1:0] lsu_r_rd;
  logic              wb_valid;
  logic              wb_rd_w_en;
  logic [ADDR_W-1:0] wb_rd;
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_is_bj;
  logic              rs1_pending;
  logic              rs2_pending;
  logic              rs1_load_pending;
  logic              rs2_load_pending;
  logic              id_stall;
  logic [OUT_W-1:0]  inflight;
  logic              err_underflow;

  modport master (
    output issue_valid, issue_rd_w_en, issue_rd, issue_is_load,
    output lsu_r_valid, lsu_r_rd, wb_valid, wb_rd_w_en, wb_rd,
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_bj,
    input  issue_ready, rs1_pending, rs2_pending, rs1_load_pending, rs2_load_pending,
    input  id_stall, inflight, err_underflow
  );

  modport slave (
    input  issue_valid, issue_rd_w_en, issue_rd, issue_is_load,
    input  lsu_r_valid, lsu_r_rd, wb_valid, wb_rd_w_en, wb_rd,
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_bj,
    output issue_ready, rs1_pending, rs2_pending, rs1_load_pending, rs2_load_pending,
    output id_stall, inflight, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard_sb_counter_bank.sv
// NREG saturating up/down counters with one increment and one decrement index per cycle,
// two write-through read ports (stored count minus same-cycle decrement) and a full check.
module sb_counter_bank
  import reg_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] inc_idx,
  input  logic              dec_en,
  input  logic [ADDR_W-1:0] dec_idx,
  input  logic [ADDR_W-1:0] rd_a_idx,
  input  logic [ADDR_W-1:0] rd_b_idx,
  input  logic [ADDR_W-1:0] chk_idx,
  output logic [CNT_W-1:0]  rd_a_cnt,
  output logic [CNT_W-1:0]  rd_b_cnt,
  output logic              chk_full,
  output logic              underflow
);
  logic [CNT_W-1:0] cnt_r [NREG];
  logic             cancel_s;

  function automatic logic [CNT_W-1:0] seen_cnt(input logic [CNT_W-1:0] cnt, input logic dec_hit);
    if (dec_hit && (cnt != CNT_ZERO)) return cnt - CNT_ONE;
    else return cnt;
  endfunction

  // Same-index inc/dec cancellation, write-through reads and underflow detect
  always_comb begin
    cancel_s  = inc_en & dec_en & (inc_idx == dec_idx);
    rd_a_cnt  = seen_cnt(cnt_r[rd_a_idx], dec_en & (dec_idx == rd_a_idx));
    rd_b_cnt  = seen_cnt(cnt_r[rd_b_idx], dec_en & (dec_idx == rd_b_idx));
    chk_full  = (cnt_r[chk_idx] == CNT_MAX);
    underflow = dec_en & ~cancel_s & (cnt_r[dec_idx] == CNT_ZERO);
  end

  // Per-entry saturating update; entry 0 is pinned to zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) cnt_r[i] <= CNT_ZERO;
    end else begin
      cnt_r[0] <= CNT_ZERO;
      for (int i = 1; i < NREG; i++) begin
        if (cancel_s) begin
          cnt_r[i] <= cnt_r[i];
        end else if (inc_en && (inc_idx == ADDR_W'(i)) && (cnt_r[i] != CNT_MAX)) begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end else if (dec_en && (dec_idx == ADDR_W'(i)) && (cnt_r[i] != CNT_ZERO)) begin
          cnt_r[i] <= cnt_r[i] - CNT_ONE;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end
endmodule

// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: tracks in-flight writers and outstanding loads per register
// and answers ID-stage hazard queries with a zero-latency stall.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input logic        clk,
  input logic        rst,
  reg_scoreboard_if.slave sb
);
  logic             issue_ready_s;
  logic             wr_inc_s, ld_inc_s, wr_dec_s, ld_dec_s;
  logic             wr_full_s, ld_full_s, wr_uf_s, ld_uf_s;
  logic [CNT_W-1:0] wr_a_s, wr_b_s, ld_a_s, ld_b_s;
  logic [OUT_W-1:0] inflight_r;
  logic             err_r;
  logic             p1_s, p2_s, lp1_s, lp2_s;

  // Event qualification; a commit to issue_rd frees a slot the same cycle
  always_comb begin
    wr_dec_s      = sb.wb_valid & sb.wb_rd_w_en & (sb.wb_rd != REG_ZERO);
    ld_dec_s      = sb.lsu_r_valid & (sb.lsu_r_rd != REG_ZERO);
    issue_ready_s = ~wr_full_s | (wr_dec_s & (sb.wb_rd == sb.issue_rd)) |
                    (sb.issue_rd == REG_ZERO) | ~sb.issue_rd_w_en;
    wr_inc_s      = sb.issue_valid & sb.issue_rd_w_en & (sb.issue_rd != REG_ZERO) & issue_ready_s;
    ld_inc_s      = wr_inc_s & sb.issue_is_load;
  end

  sb_counter_bank u_wr_cnt (
    .clk(clk), .rst(rst),
    .inc_en(wr_inc_s), .inc_idx(sb.issue_rd),
    .dec_en(wr_dec_s), .dec_idx(sb.wb_rd),
    .rd_a_idx(sb.id_rs1), .rd_b_idx(sb.id_rs2), .chk_idx(sb.issue_rd),
    .rd_a_cnt(wr_a_s), .rd_b_cnt(wr_b_s), .chk_full(wr_full_s), .underflow(wr_uf_s)
  );

  sb_counter_bank u_ld_cnt (
    .clk(clk), .rst(rst),
    .inc_en(ld_inc_s), .inc_idx(sb.issue_rd),
    .dec_en(ld_dec_s), .dec_idx(sb.lsu_r_rd),
    .rd_a_idx(sb.id_rs1), .rd_b_idx(sb.id_rs2), .chk_idx(sb.issue_rd),
    .rd_a_cnt(ld_a_s), .rd_b_cnt(ld_b_s), .chk_full(ld_full_s), .underflow(ld_uf_s)
  );

  // ID queries and stall; plain ALU hazards are left to forwarding unless ID resolves a branch
  always_comb begin
    p1_s  = sb.id_use_rs1 & (sb.id_rs1 != REG_ZERO) & (wr_a_s != CNT_ZERO);
    p2_s  = sb.id_use_rs2 & (sb.id_rs2 != REG_ZERO) & (wr_b_s != CNT_ZERO);
    lp1_s = sb.id_use_rs1 & (sb.id_rs1 != REG_ZERO) & (ld_a_s != CNT_ZERO);
    lp2_s = sb.id_use_rs2 & (sb.id_rs2 != REG_ZERO) & (ld_b_s != CNT_ZERO);
    sb.rs1_pending      = p1_s;
    sb.rs2_pending      = p2_s;
    sb.rs1_load_pending = lp1_s;
    sb.rs2_load_pending = lp2_s;
    sb.id_stall         = lp1_s | lp2_s | (sb.id_is_bj & (p1_s | p2_s));
    sb.issue_ready      = issue_ready_s;
    sb.inflight         = inflight_r;
    sb.err_underflow    = err_r;
  end

  // Total in-flight count (clamped both ways) and sticky underflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_r <= INFL_ZERO;
      err_r      <= 1'b0;
    end else begin
      case ({wr_inc_s, wr_dec_s})
        2'b10:   inflight_r <= (inflight_r != INFL_MAX)  ? inflight_r + INFL_ONE : inflight_r;
        2'b01:   inflight_r <= (inflight_r != INFL_ZERO) ? inflight_r - INFL_ONE : inflight_r;
        default: inflight_r <= inflight_r;
      endcase
      err_r <= err_r | wr_uf_s | ld_uf_s;
    end
  end

  logic unused_s;
  assign unused_s = ld_full_s;
endmodule
